multi_timer_ip: RTL and testbench
=================================

// Module: multi_timer_ip
// PURPOSE
//  Parametrised multi-channel down-counting timer on the simple sel/we/addr/wdata/rdata peripheral bus.
//  NCH independent channels; each has one-shot or periodic mode, an 8-bit prescaler, live VALUE readback,
//  sticky timeout plus overrun status, and a per-channel expire pulse.
//  All channel timeouts are masked and ORed into the single interrupt line to the CPU.
// PARAMETERS
//  NCH      4   number of channels, 1..15
//  CNT_W    32  counter/LOAD width, 1..32; unused upper register bits read 0, writes to them are ignored
//  PRESC_W  8   prescaler field width, 1..8; tick divide ratio = PRESC+1
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  resetn        in   1       asynchronous, active-low reset
//  sel           in   1       bus select
//  we            in   1       1 = write, 0 = read (qualified by sel)
//  addr          in   8       byte address; [7:4] = channel or 0xF global page, [3:2] = register
//  wdata         in   32      write data
//  rdata         out  32      read data
//  timeout_irq   out  1       level interrupt = |(STATUS.TO & IRQ_MASK)
//  expire_pulse  out  NCH     1-cycle pulse per channel at each expiry
// BEHAVIOUR
//  Register map, channel c at c*0x10:
//   +0x0 CTRL RW:    [0] EN, [1] MODE (1 = periodic), [15:8] PRESC
//   +0x4 LOAD RW
//   +0x8 VALUE RO:   live count
//   +0xC STATUS:     [0] TO, [1] OVR; write-1-to-clear
//  Global page:
//   0xF0 IRQ_MASK RW [NCH-1:0]
//   0xF4 IRQ_PEND RO [NCH-1:0] = TO bits, unmasked
//  Unmapped reads (incl. channel >= NCH) return 0; unmapped writes are ignored.
//  Write = sel&we, takes effect at that rising edge.
//  rdata is combinational: decode of addr when sel&!we, else 0.
//  Reset (async, any time, incl. mid-count): all CTRL/LOAD/VALUE/STATUS/MASK/prescalers = 0;
//   timeout_irq = 0, expire_pulse = 0, rdata = 0.
//  Any write to CTRL with EN=1 (re)starts the channel:
//   VALUE <= LOAD, prescaler <= 0, pending tick discarded; EN=1 to a running channel also restarts.
//  Writing CTRL with EN=0 freezes VALUE; STATUS is kept.
//  Prescaler: while EN, increments each cycle; on reaching PRESC it wraps to 0 and issues a tick.
//   PRESC=0 -> tick every cycle.
//  On tick:
//   VALUE > 1       -> VALUE <= VALUE-1
//   VALUE <= 1      -> expire: TO <= 1; OVR <= 1 if TO already set; expire_pulse[c] high for the next cycle;
//                      periodic: VALUE <= LOAD; one-shot: VALUE <= 0 and EN <= 0
//  Timing:
//   LOAD=N, PRESC=P: first expiry N*(P+1) cycles after the CTRL write edge; LOAD=0 behaves as LOAD=1.
//   Periodic: subsequent expiries every N*(P+1) cycles.
//  LOAD writes while running: no effect on VALUE until the next restart or periodic reload.
//  Same-cycle STATUS W1C and expiry: set wins (TO stays 1); OVR is evaluated against pre-clear TO.
//  CTRL restart write in the same cycle as an expiry: restart wins, no TO set, no pulse.
//  timeout_irq is combinational from registered TO/MASK: high the cycle after the expiry edge,
//   low the cycle after the W1C clear edge.
//  Counters never wrap below 0; VALUE width is CNT_W, arithmetic is unsigned.
// TESTING
//  ch0 LOAD=10, CTRL=0x1 -> expire_pulse[0] and TO 10 cycles after the write; EN self-clears;
//   VALUE reads 0; no further pulses.
//  MASK=0x1, ch0 LOAD=5, CTRL=0x3 -> irq every 5 cycles; W1C STATUS=0x1 drops irq next cycle;
//   skipping a clear sets OVR=1.
//  ch1 LOAD=5, CTRL=0x405 (PRESC=4) -> expiry after 25 cycles; VALUE decrements every 5 cycles.
//  ch0 and ch2 periodic LOAD=3/7, MASK=0x4 -> both pulse; IRQ_PEND=0x5; irq tracks only ch2.
//  W1C on the exact expiry cycle -> TO remains 1; resetn low mid-count -> all outputs 0 immediately.
//  LOAD=0 periodic -> pulse every (PRESC+1) cycles; read of addr 0x40 with NCH=4 -> 0.

Source files
------------

// File: rtl/multi_timer_ip.sv
// Multi-channel down-counting timer on the sel/we/addr/wdata/rdata bus.
// One multi_timer_ch per channel; top holds the decode, IRQ mask and read mux.

module multi_timer_ch #(
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               ctrl_we,
   input  logic               load_we,
   input  logic               stat_we,
   input  logic [31:0]        wdata,
   output logic               en,
   output logic               mode,
   output logic [PRESC_W-1:0] presc,
   output logic [CNT_W-1:0]   load,
   output logic [CNT_W-1:0]   value,
   output logic               to,
   output logic               ovr,
   output logic               expire_pulse
);

   logic [PRESC_W-1:0] pcnt;
   logic               tick, expire, expire_q;
   logic               unused_wdata;

   assign unused_wdata = ^wdata;
   // >= rather than == so a PRESC lowered mid-run cannot strand the prescaler
   assign tick     = en && (pcnt >= presc);
   assign expire   = tick && (value <= CNT_W'(1));
   // a CTRL write owns the channel that cycle: no expiry is recorded
   assign expire_q = expire && !ctrl_we;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en           <= 1'b0;
         mode         <= 1'b0;
         presc        <= '0;
         load         <= '0;
         value        <= '0;
         pcnt         <= '0;
         to           <= 1'b0;
         ovr          <= 1'b0;
         expire_pulse <= 1'b0;
      end else begin
         expire_pulse <= expire_q;
         if (load_we)
            load <= wdata[CNT_W-1:0];
         if (ctrl_we) begin
            en    <= wdata[0];
            mode  <= wdata[1];
            presc <= wdata[8 +: PRESC_W];
            if (wdata[0]) begin
               value <= load;
               pcnt  <= '0;
            end
         end else if (en) begin
            if (tick) begin
               pcnt <= '0;
               if (value > CNT_W'(1))
                  value <= value - CNT_W'(1);
               else if (mode)
                  value <= load;
               else begin
                  value <= '0;
                  en    <= 1'b0;
               end
            end else begin
               pcnt <= pcnt + PRESC_W'(1);
            end
         end
         // set beats clear; OVR looks at TO before any clear this cycle
         to  <= (to  & ~(stat_we & wdata[0])) | expire_q;
         ovr <= (ovr & ~(stat_we & wdata[1])) | (expire_q & to);
      end
   end

endmodule

module multi_timer_ip #(
   parameter int NCH     = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sel,
   input  logic             we,
   input  logic [7:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             timeout_irq,
   output logic [NCH-1:0]   expire_pulse
);

   logic [3:0]                    chan;
   logic [1:0]                    rsel;
   logic                          wr;
   logic [NCH-1:0]                irq_mask;
   logic [NCH-1:0]                en_v, mode_v, to_v, ovr_v;
   logic [NCH-1:0][PRESC_W-1:0]   presc_v;
   logic [NCH-1:0][CNT_W-1:0]     load_v, value_v;
   logic                          unused_addr;

   assign chan        = addr[7:4];
   assign rsel        = addr[3:2];
   assign wr          = sel && we;
   assign unused_addr = ^addr[1:0];
   assign timeout_irq = |(to_v & irq_mask);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         irq_mask <= '0;
      else if (wr && chan == 4'hF && rsel == 2'd0)
         irq_mask <= wdata[NCH-1:0];
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic hit;
      assign hit = wr && (chan == 4'(c));
      multi_timer_ch #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_ch (
         .clk          (clk),
         .resetn       (resetn),
         .ctrl_we      (hit && rsel == 2'd0),
         .load_we      (hit && rsel == 2'd1),
         .stat_we      (hit && rsel == 2'd3),
         .wdata        (wdata),
         .en           (en_v[c]),
         .mode         (mode_v[c]),
         .presc        (presc_v[c]),
         .load         (load_v[c]),
         .value        (value_v[c]),
         .to           (to_v[c]),
         .ovr          (ovr_v[c]),
         .expire_pulse (expire_pulse[c])
      );
   end

   always_comb begin
      rdata = '0;
      if (sel && !we) begin
         if (chan == 4'hF) begin
            case (rsel)
               2'd0:    rdata[NCH-1:0] = irq_mask;
               2'd1:    rdata[NCH-1:0] = to_v;
               default: rdata = '0;
            endcase
         end else begin
            for (int c = 0; c < NCH; c++) begin
               if (chan == 4'(c)) begin
                  case (rsel)
                     2'd0: begin
                        rdata[0]            = en_v[c];
                        rdata[1]            = mode_v[c];
                        rdata[8 +: PRESC_W] = presc_v[c];
                     end
                     2'd1:    rdata[CNT_W-1:0] = load_v[c];
                     2'd2:    rdata[CNT_W-1:0] = value_v[c];
                     default: rdata[1:0]       = {ovr_v[c], to_v[c]};
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_timer_ip.sv
// Directed bench for multi_timer_ip (NCH=4): one-shot, periodic, prescaler, IRQ mask,
// W1C/expiry collision, restart collision, async reset and unmapped reads.

module tb_multi_timer_ip;

   logic        clk = 1'b0;
   logic        resetn;
   logic        sel, we;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        timeout_irq;
   logic [3:0]  expire_pulse;

   int total = 0;
   int bad   = 0;
   int pcnt[4];
   int first[4];
   logic [31:0] rd;

   always #5 clk = ~clk;

   multi_timer_ip #(.NCH(4), .CNT_W(32), .PRESC_W(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .sel          (sel),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .timeout_irq  (timeout_irq),
      .expire_pulse (expire_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = a;
      #1 d = rdata;
      sel = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_count(input int n);
      for (int c = 0; c < 4; c++) begin
         pcnt[c]  = 0;
         first[c] = -1;
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         for (int c = 0; c < 4; c++)
            if (expire_pulse[c]) begin
               pcnt[c]++;
               if (first[c] < 0) first[c] = k;
            end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      #22;
      sel = 1'b1; addr = 8'hF0;
      #1;
      chk("rst_irq",   {31'd0, timeout_irq}, 32'd0);
      chk("rst_pulse", {28'd0, expire_pulse}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      sel = 1'b0;
      @(negedge clk) resetn = 1'b1;

      // one-shot: LOAD=10 -> single pulse 10 cycles after the CTRL edge
      bus_wr(8'h04, 32'd10);
      bus_wr(8'h00, 32'h1);
      run_count(20);
      chk("os_first", first[0], 10);
      chk("os_count", pcnt[0], 1);
      bus_rd(8'h0C, rd); chk("os_status", rd, 32'h1);
      bus_rd(8'h00, rd); chk("os_ctrl_en_clr", rd, 32'h0);
      bus_rd(8'h08, rd); chk("os_value", rd, 32'd0);
      chk("os_irq_masked", {31'd0, timeout_irq}, 32'd0);

      // periodic LOAD=5 with ch0 unmasked
      bus_wr(8'hF0, 32'h1);
      bus_wr(8'h0C, 32'h3);
      bus_wr(8'h04, 32'd5);
      bus_wr(8'h00, 32'h3);
      step(4);  chk("per_irq_pre", {31'd0, timeout_irq}, 32'd0);
      step(1);  chk("per_irq_set", {31'd0, timeout_irq}, 32'd1);
      chk("per_pulse", {31'd0, expire_pulse[0]}, 32'd1);
      bus_wr(8'h0C, 32'h1);
      chk("per_irq_clr", {31'd0, timeout_irq}, 32'd0);
      step(4);  chk("per_irq_2nd", {31'd0, timeout_irq}, 32'd1);
      bus_rd(8'h0C, rd); chk("per_status_to", rd, 32'h1);
      step(5);
      bus_rd(8'h0C, rd); chk("per_status_ovr", rd, 32'h3);
      bus_wr(8'h00, 32'h0);
      bus_wr(8'h0C, 32'h3);
      chk("per_irq_off", {31'd0, timeout_irq}, 32'd0);

      // ch1 prescaled: LOAD=5, PRESC=4 -> VALUE steps every 5, expiry at 25
      bus_wr(8'h14, 32'd5);
      bus_wr(8'h10, 32'h405);
      step(4);  bus_rd(8'h18, rd); chk("psc_val_5", rd, 32'd5);
      step(1);  bus_rd(8'h18, rd); chk("psc_val_4", rd, 32'd4);
      step(19); chk("psc_pulse_pre", {31'd0, expire_pulse[1]}, 32'd0);
      step(1);  chk("psc_pulse", {31'd0, expire_pulse[1]}, 32'd1);
      bus_rd(8'h18, rd); chk("psc_val_0", rd, 32'd0);
      bus_rd(8'h1C, rd); chk("psc_status", rd, 32'h1);
      bus_wr(8'h1C, 32'h3);

      // ch0 LOAD=3 and ch2 LOAD=7 periodic, only ch2 unmasked
      bus_wr(8'hF0, 32'h4);
      bus_wr(8'h04, 32'd3);
      bus_wr(8'h24, 32'd7);
      bus_wr(8'h00, 32'h3);
      bus_wr(8'h20, 32'h3);
      run_count(21);
      chk("dual_cnt0", pcnt[0], 7);
      chk("dual_cnt2", pcnt[2], 3);
      bus_rd(8'hF4, rd); chk("dual_pend", rd, 32'h5);
      chk("dual_irq", {31'd0, timeout_irq}, 32'd1);
      bus_wr(8'h2C, 32'h1);
      chk("dual_irq_clr", {31'd0, timeout_irq}, 32'd0);
      bus_rd(8'hF4, rd); chk("dual_pend_ch0", rd, 32'h1);
      bus_wr(8'h00, 32'h0);
      bus_wr(8'h20, 32'h0);
      bus_wr(8'h0C, 32'h3);
      bus_wr(8'h2C, 32'h3);

      // restart write on the expiry edge wins: no pulse, no TO
      bus_wr(8'h34, 32'd2);
      bus_wr(8'h30, 32'h3);
      step(1);
      bus_wr(8'h30, 32'h3);
      chk("rst_win_pulse", {31'd0, expire_pulse[3]}, 32'd0);
      bus_rd(8'h3C, rd); chk("rst_win_status", rd, 32'h0);
      step(1);  chk("rst_win_pre", {31'd0, expire_pulse[3]}, 32'd0);
      step(1);  chk("rst_win_next", {31'd0, expire_pulse[3]}, 32'd1);
      bus_wr(8'h30, 32'h0);

      // W1C on the exact expiry edge: TO stays set
      bus_wr(8'hF0, 32'h1);
      bus_wr(8'h04, 32'd4);
      bus_wr(8'h00, 32'h3);
      step(3);
      bus_wr(8'h0C, 32'h1);
      chk("w1c_pulse", {31'd0, expire_pulse[0]}, 32'd1);
      bus_rd(8'h0C, rd); chk("w1c_to_kept", rd, 32'h1);
      chk("w1c_irq", {31'd0, timeout_irq}, 32'd1);

      // async reset mid-count
      @(negedge clk); #2;
      resetn = 1'b0;
      sel = 1'b1; we = 1'b0; addr = 8'h04;
      #1;
      chk("ar_irq",   {31'd0, timeout_irq}, 32'd0);
      chk("ar_pulse", {28'd0, expire_pulse}, 32'd0);
      chk("ar_rdata", rdata, 32'd0);
      sel = 1'b0;
      @(negedge clk) resetn = 1'b1;
      bus_rd(8'h08, rd); chk("ar_value", rd, 32'd0);
      bus_rd(8'hF0, rd); chk("ar_mask", rd, 32'd0);

      // LOAD=0 periodic, PRESC=2 -> pulse every 3 cycles
      bus_wr(8'h04, 32'd0);
      bus_wr(8'h00, 32'h203);
      run_count(12);
      chk("l0_first", first[0], 3);
      chk("l0_count", pcnt[0], 4);
      bus_wr(8'h00, 32'h0);

      // unmapped reads
      bus_rd(8'h40, rd); chk("unmap_ch4", rd, 32'd0);
      bus_rd(8'hF8, rd); chk("unmap_glob", rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
